// File: rtl/dlx_seq_ctrl_if.sv
// Bundle between the DLX control sequencer and the decoder / memory / datapath side.
// i_req (d_req) stays high until i_ready (d_ready) is seen high on a clk edge; readies are ignored otherwise.
`timescale 1ns/1ps
interface dlx_seq_ctrl_if #(
    parameter int CNT_W = 32
);
    logic             halt_req;
    logic             i_ready;
    logic             d_ready;
    logic             d_load_enable;
    logic             d_write_enable;
    logic [4:0]       Rd;
    logic [1:0]       Pc_cmd;

    logic             IF;
    logic             ID;
    logic             EX;
    logic             MEM;
    logic             WB;
    logic             i_req;
    logic             d_req;
    logic             rf_write_enable;
    logic             pc_update;
    logic             pc_redirect;
    logic             halted;
    logic             bus_error;
    logic [CNT_W-1:0] instret;
    logic [2:0]       state_dbg;

    // master: the sequencer; slave: decoder, memories and datapath
    modport master (
        input  halt_req, i_ready, d_ready, d_load_enable, d_write_enable, Rd, Pc_cmd,
        output IF, ID, EX, MEM, WB, i_req, d_req, rf_write_enable, pc_update,
               pc_redirect, halted, bus_error, instret, state_dbg
    );

    modport slave (
        output halt_req, i_ready, d_ready, d_load_enable, d_write_enable, Rd, Pc_cmd,
        input  IF, ID, EX, MEM, WB, i_req, d_req, rf_write_enable, pc_update,
               pc_redirect, halted, bus_error, instret, state_dbg
    );
endinterface

// File: rtl/dlx_seq_ctrl.sv
// Multi-cycle DLX control sequencer: FETCH/DECODE/EXEC/MEM/WBACK with bounded memory waits,
// halt at instruction boundaries, sticky bus error and a retired-instruction counter.
`timescale 1ns/1ps
module dlx_seq_ctrl #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 32
) (
    input  logic           clk,
    input  logic           reset_n,
    dlx_seq_ctrl_if.master bus
);
    typedef enum logic [2:0] {
        S_BOOT   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WBACK  = 3'd5,
        S_HALT   = 3'd6,
        S_ERROR  = 3'd7
    } state_t;

    localparam int             WC_W    = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [WC_W-1:0] WC_LAST = WC_W'(TIMEOUT - 1);

    state_t           state;
    state_t           state_next;
    logic [WC_W-1:0]  wait_cnt;
    logic             bus_error_q;
    logic [CNT_W-1:0] instret_q;

    always_ff @(posedge clk) begin
        if (!reset_n) state <= S_BOOT;
        else          state <= state_next;
    end

    // A ready seen on the last allowed wait cycle still completes the access.
    always_comb begin
        state_next = state;
        case (state)
            S_BOOT:   state_next = bus.halt_req ? S_HALT : S_FETCH;
            S_FETCH: begin
                if (bus.i_ready)              state_next = S_DECODE;
                else if (wait_cnt == WC_LAST) state_next = S_ERROR;
            end
            S_DECODE: state_next = S_EXEC;
            S_EXEC:   state_next = (bus.d_load_enable || bus.d_write_enable) ? S_MEM : S_WBACK;
            S_MEM: begin
                if (bus.d_ready)              state_next = S_WBACK;
                else if (wait_cnt == WC_LAST) state_next = S_ERROR;
            end
            S_WBACK:  state_next = bus.halt_req ? S_HALT : S_FETCH;
            S_HALT:   if (!bus.halt_req) state_next = S_FETCH;
            S_ERROR:  state_next = S_ERROR;
            default:  state_next = S_BOOT;
        endcase
    end

    always_comb begin
        bus.IF              = 1'b0;
        bus.ID              = 1'b0;
        bus.EX              = 1'b0;
        bus.MEM             = 1'b0;
        bus.WB              = 1'b0;
        bus.i_req           = 1'b0;
        bus.d_req           = 1'b0;
        bus.rf_write_enable = 1'b0;
        bus.pc_update       = 1'b0;
        bus.pc_redirect     = 1'b0;
        bus.halted          = 1'b0;
        case (state)
            S_FETCH: begin
                bus.IF    = 1'b1;
                bus.i_req = 1'b1;
            end
            S_DECODE: bus.ID = 1'b1;
            S_EXEC:   bus.EX = 1'b1;
            S_MEM: begin
                bus.MEM   = 1'b1;
                bus.d_req = 1'b1;
            end
            S_WBACK: begin
                bus.WB              = 1'b1;
                bus.pc_update       = 1'b1;
                // r0 is hardwired zero and stores have no register result
                bus.rf_write_enable = (bus.Rd != 5'd0) && !bus.d_write_enable;
                bus.pc_redirect     = (bus.Pc_cmd != 2'd0);
            end
            S_HALT:   bus.halted = 1'b1;
            default: ;
        endcase
    end

    // Wait counter restarts on every state entry so FETCH and MEM each get a full budget.
    always_ff @(posedge clk) begin
        if (!reset_n)
            wait_cnt <= '0;
        else if (state_next != state)
            wait_cnt <= '0;
        else if (state == S_FETCH || state == S_MEM)
            wait_cnt <= wait_cnt + WC_W'(1);
        else
            wait_cnt <= '0;
    end

    always_ff @(posedge clk) begin
        if (!reset_n)                 bus_error_q <= 1'b0;
        else if (state_next == S_ERROR) bus_error_q <= 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!reset_n)             instret_q <= '0;
        else if (state == S_WBACK) instret_q <= instret_q + CNT_W'(1);
    end

    assign bus.bus_error = bus_error_q;
    assign bus.instret   = instret_q;
    assign bus.state_dbg = state;
endmodule

// File: tb/tb_dlx_seq_ctrl.sv
// Bench for dlx_seq_ctrl: directed boundary sequences, then random instructions checked
// through an expected-retirement queue against a cycle-count model of each instruction.
`timescale 1ns/1ps
module tb_dlx_seq_ctrl;
  localparam int TIMEOUT = 16;
  localparam int CNT_W   = 32;
  localparam int N_RAND  = 40;

  logic clk = 1'b0;
  logic reset_n = 1'b0;

  dlx_seq_ctrl_if #(.CNT_W(CNT_W)) bus ();

  dlx_seq_ctrl #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk(clk),
    .reset_n(reset_n),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_fail = 0;
  logic [10:0] exp_q[$];
  int retired = 0;
  logic drv_en = 1'b0;
  logic mon_en = 1'b0;

  // ---------------- helpers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // {IF,ID,EX,MEM,WB,i_req,d_req,rf_we,pc_update,pc_redirect,halted,bus_error}
  function automatic logic [31:0] outs();
    return {20'd0, bus.IF, bus.ID, bus.EX, bus.MEM, bus.WB, bus.i_req, bus.d_req,
            bus.rf_write_enable, bus.pc_update, bus.pc_redirect, bus.halted, bus.bus_error};
  endfunction

  localparam logic [31:0] O_FETCH  = 32'h840;
  localparam logic [31:0] O_DECODE = 32'h400;
  localparam logic [31:0] O_EXEC   = 32'h200;
  localparam logic [31:0] O_MEM    = 32'h120;
  localparam logic [31:0] O_HALT   = 32'h002;
  localparam logic [31:0] O_ERROR  = 32'h001;

  // ---------------- random driver: reactive memories + decoder ----------------
  int cur_iw, cur_dw, fcnt, mcnt;
  logic in_fetch = 1'b0;
  logic in_mem = 1'b0;

  always begin
    @(posedge clk);
    #1;
    if (drv_en) begin
      if (bus.IF) begin
        if (!in_fetch) begin
          int kind, rd, pc, lat;
          logic is_mem;
          kind = $urandom_range(0, 3);
          rd = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 31);
          pc = (kind == 3) ? $urandom_range(1, 3) : 0;
          cur_iw = $urandom_range(0, 5);
          cur_dw = $urandom_range(0, 5);
          is_mem = (kind == 1) || (kind == 2);
          bus.d_load_enable  = (kind == 1);
          bus.d_write_enable = (kind == 2);
          bus.Rd = 5'(rd);
          bus.Pc_cmd = 2'(pc);
          lat = (cur_iw + 1) + 2 + (is_mem ? cur_dw + 1 : 0) + 1;
          exp_q.push_back({(rd != 0) && (kind != 2), pc != 0, 1'b1, 8'(lat)});
          fcnt = 0;
        end
        bus.i_ready = (fcnt == cur_iw);
        fcnt++;
        in_fetch = 1'b1;
      end else begin
        in_fetch = 1'b0;
        bus.i_ready = 1'($urandom_range(0, 1));
      end
      if (bus.MEM) begin
        if (!in_mem) mcnt = 0;
        bus.d_ready = (mcnt == cur_dw);
        mcnt++;
        in_mem = 1'b1;
      end else begin
        in_mem = 1'b0;
        bus.d_ready = 1'($urandom_range(0, 1));
      end
    end
  end

  // ---------------- monitor / scoreboard ----------------
  int lat_cnt = 0;
  logic prev_if = 1'b0;
  logic chk_instret = 1'b0;
  logic [31:0] exp_instret = 0;

  always @(negedge clk) begin
    if (mon_en) begin
      if (bus.IF && !prev_if) lat_cnt = 1;
      else lat_cnt++;
      prev_if = bus.IF;
      chk("one_hot_stage", 32'($countones({bus.IF, bus.ID, bus.EX, bus.MEM, bus.WB})), 1);
      chk("req_match", {30'd0, bus.i_req, bus.d_req}, {30'd0, bus.IF, bus.MEM});
      if (chk_instret) begin
        chk("instret_count", bus.instret, exp_instret);
        chk_instret = 1'b0;
      end
      if (bus.WB) begin
        if (exp_q.size() == 0) begin
          chk("wb_unexpected", 1, 0);
        end else begin
          logic [10:0] e;
          e = exp_q.pop_front();
          chk("wb_result", {21'd0, bus.rf_write_enable, bus.pc_redirect, bus.pc_update, 8'(lat_cnt)},
              {21'd0, e});
        end
        exp_instret++;
        chk_instret = 1'b1;
        retired++;
      end
    end
  end

  // ---------------- main sequence ----------------
  initial begin
    bus.halt_req = 1'b0;
    bus.i_ready = 1'b0;
    bus.d_ready = 1'b0;
    bus.d_load_enable = 1'b0;
    bus.d_write_enable = 1'b0;
    bus.Rd = 5'd0;
    bus.Pc_cmd = 2'd0;
    reset_n = 1'b0;
    step();
    step();
    chk("reset_outs", outs(), 0);
    chk("reset_instret", bus.instret, 0);

    // BOOT with halt_req goes straight to HALT
    bus.halt_req = 1'b1;
    reset_n = 1'b1;
    step();
    chk("boot_to_halt", outs(), O_HALT);
    step();
    chk("halt_hold", outs(), O_HALT);
    bus.halt_req = 1'b0;
    step();
    chk("halt_exit_fetch", outs(), O_FETCH);

    // fetch timeout: 16 FETCH cycles then ERROR
    repeat (TIMEOUT - 1) step();
    chk("fetch_cycle_16", outs(), O_FETCH);
    step();
    chk("fetch_timeout", outs(), O_ERROR);
    bus.i_ready = 1'b1;
    repeat (3) step();
    chk("error_sticky", outs(), O_ERROR);
    reset_n = 1'b0;
    step();
    chk("error_reset", outs(), 0);
    bus.i_ready = 1'b0;
    reset_n = 1'b1;
    step();
    chk("boot_to_fetch", outs(), O_FETCH);

    // load with d_ready on the 16th MEM cycle
    bus.i_ready = 1'b1;
    step();
    chk("decode", outs(), O_DECODE);
    bus.i_ready = 1'b0;
    bus.d_load_enable = 1'b1;
    bus.Rd = 5'd5;
    step();
    chk("exec", outs(), O_EXEC);
    step();
    repeat (TIMEOUT - 2) step();
    chk("mem_cycle_15", outs(), O_MEM);
    step();
    chk("mem_cycle_16", outs(), O_MEM);
    bus.d_ready = 1'b1;
    step();
    chk("mem_last_ready_wb", outs(), 32'h098);
    chk("instret_before_retire", bus.instret, 0);
    bus.d_ready = 1'b0;
    step();
    chk("after_load_fetch", outs(), O_FETCH);
    chk("instret_1", bus.instret, 1);

    // jump with halt raised during EXEC: completes, then parks
    bus.d_load_enable = 1'b0;
    bus.i_ready = 1'b1;
    step();
    bus.i_ready = 1'b0;
    bus.Pc_cmd = 2'b10;
    bus.Rd = 5'd31;
    step();
    chk("jump_exec", outs(), O_EXEC);
    bus.halt_req = 1'b1;
    step();
    chk("jump_wb", outs(), 32'h09C);
    step();
    chk("halt_after_wb", outs(), O_HALT);
    chk("instret_2", bus.instret, 2);
    step();
    chk("instret_frozen", bus.instret, 2);
    bus.halt_req = 1'b0;
    step();
    chk("halt_release_fetch", outs(), O_FETCH);

    // reset in the middle of a store's MEM stage
    bus.i_ready = 1'b1;
    step();
    bus.i_ready = 1'b0;
    bus.d_write_enable = 1'b1;
    bus.Rd = 5'd0;
    bus.Pc_cmd = 2'd0;
    step();
    step();
    chk("store_mem", outs(), O_MEM);
    reset_n = 1'b0;
    step();
    chk("mid_mem_reset_outs", outs(), 0);
    chk("mid_mem_reset_instret", bus.instret, 0);

    // random instruction stream
    drv_en = 1'b1;
    step();
    reset_n = 1'b1;
    step();
    mon_en = 1'b1;
    for (int c = 0; c < 4000 && retired < N_RAND; c++) step();
    mon_en = 1'b0;
    drv_en = 1'b0;
    chk("random_retired", retired, N_RAND);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
